// File: rtl/ascii_int_parser.sv
// ASCII byte stream to signed integer records with a one-entry output register.
// Record valid the cycle after its delimiter; input stalls while the record is held.
module ascii_int_parser #(
   parameter int VALUE_WIDTH    = 32,
   parameter bit ALLOW_NEGATIVE = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [7:0]             in_data,
   output logic                   in_ready,
   output logic                   out_valid,
   output logic [VALUE_WIDTH-1:0] out_data,
   output logic                   out_eol,
   output logic                   out_blank,
   input  logic                   out_ready,
   output logic                   overflow,
   output logic                   error
);

   typedef enum logic [1:0] {
      IDLE,
      SIGN,
      NUM
   } state_t;

   state_t                 state;
   logic [VALUE_WIDTH-1:0] acc;
   logic                   sign;

   logic                   accept;
   logic                   is_digit;
   logic                   is_minus;
   logic                   is_cr;
   logic                   is_lf;
   logic [3:0]             digit;
   logic [VALUE_WIDTH+3:0] acc_ext;
   logic [VALUE_WIDTH+3:0] acc_next;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
   assign is_minus = ALLOW_NEGATIVE && (in_data == 8'h2D);
   assign is_cr    = (in_data == 8'h0D);
   assign is_lf    = (in_data == 8'h0A);
   assign digit    = in_data[3:0];

   // acc*10 + d kept four bits wider so the overflow carry is visible
   assign acc_ext  = {4'b0000, acc};
   assign acc_next = (acc_ext << 3) + (acc_ext << 1) + {{VALUE_WIDTH{1'b0}}, digit};

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         sign      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_eol   <= 1'b0;
         out_blank <= 1'b0;
         overflow  <= 1'b0;
         error     <= 1'b0;
      end else begin
         if (out_valid && out_ready)
            out_valid <= 1'b0;

         // A new record may load in the same cycle the old one drains
         if (accept && !is_cr) begin
            case (state)
               IDLE: begin
                  if (is_digit) begin
                     acc   <= VALUE_WIDTH'(digit);
                     state <= NUM;
                  end else if (is_minus) begin
                     sign  <= 1'b1;
                     state <= SIGN;
                  end else if (is_lf) begin
                     out_valid <= 1'b1;
                     out_data  <= '0;
                     out_eol   <= 1'b1;
                     out_blank <= 1'b1;
                  end
               end
               SIGN: begin
                  if (is_digit) begin
                     acc   <= VALUE_WIDTH'(digit);
                     state <= NUM;
                  end else begin
                     error <= 1'b1;
                     sign  <= 1'b0;
                     state <= IDLE;
                  end
               end
               NUM: begin
                  if (is_digit) begin
                     acc <= acc_next[VALUE_WIDTH-1:0];
                     if (|acc_next[VALUE_WIDTH+3:VALUE_WIDTH])
                        overflow <= 1'b1;
                  end else begin
                     out_valid <= 1'b1;
                     out_data  <= sign ? ('0 - acc) : acc;
                     out_eol   <= is_lf;
                     out_blank <= 1'b0;
                     sign      <= 1'b0;
                     acc       <= '0;
                     state     <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
